uart_tx_arbiter: RTL

Shares one uart transmitter among N_REQ requesters. Each requester presents a character; the arbiter grants one at a time (round-robin), drives the uart send/send_data handshake, waits for the uart "sent" indication and returns a per-requester done pulse. A watchdog aborts a transfer whose sent never arrives. It sits between client logic and the uart send port, in the uart's transmit clock domain.

---
 rtl/uart_tx_arbiter_if.sv | 21 ++
 rtl/uart_tx_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Uart transmit port bundle between the arbiter and the uart.
// The arbiter drives send/data; the uart reports completion.
interface uart_tx_arbiter_if #(
  parameter int DATA_W = 7
);
  logic              uart_send;
  logic [DATA_W-1:0] uart_send_data;
  logic              uart_sent;

  modport master (
    output uart_send,
    output uart_send_data,
    input  uart_sent
  );

  modport slave (
    input  uart_send,
    input  uart_send_data,
    output uart_sent
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart transmitter among N_REQ
// clients, with a watchdog that aborts a transfer never sent.
module uart_tx_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_W     = 7,
  parameter int SEND_PULSE = 2,
  parameter int TIMEOUT    = 4096
) (
  input  logic                    clk,
  input  logic                    rstN,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        done,
  output logic                    err,
  output logic                    busy,
  uart_tx_arbiter_if.master       uart
);

  localparam int PW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PCW = $clog2(SEND_PULSE + 1);
  localparam int WDW = $clog2(TIMEOUT + 1);

  localparam logic [PCW-1:0] PC_LAST = PCW'(SEND_PULSE - 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [PW:0]    N_W     = (PW + 1)'(N_REQ);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_LOW,
    WAIT_SENT,
    DONE
  } state_t;

  state_t state, state_n;

  logic [PW-1:0]     ptr, ptr_n;
  logic [PCW-1:0]    pcnt, pcnt_n;
  logic [WDW-1:0]    wdog, wdog_n;
  logic [N_REQ-1:0]  grant_n, done_n;
  logic              err_n;
  logic              send_q, send_n;
  logic [DATA_W-1:0] data_q, data_n;

  logic [DATA_W-1:0] rd [N_REQ];
  logic              any;
  logic [PW-1:0]     sel;
  logic [PW-1:0]     sel_nxt;
  logic [PW:0]       sum;
  logic              tout;

  assign uart.uart_send      = send_q;
  assign uart.uart_send_data = data_q;

  for (genvar g = 0; g < N_REQ; g++) begin : g_rd
    assign rd[g] = req_data[g*DATA_W +: DATA_W];
  end

  // Rotating priority search: first request at or above ptr.
  always_comb begin
    any = 1'b0;
    sel = '0;
    sum = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr} + (PW + 1)'(i);
      if (sum >= N_W) sum = sum - N_W;
      if (!any && req[sum[PW-1:0]]) begin
        any = 1'b1;
        sel = sum[PW-1:0];
      end
    end
  end

  // Pointer moves one past the winner, wrapping at N_REQ.
  always_comb begin
    sel_nxt = sel + PW'(1);
    if ({1'b0, sel} == N_W - (PW + 1)'(1)) sel_nxt = '0;
  end

  assign tout = (wdog == WD_LAST);

  // Next-state and next registered outputs.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    pcnt_n  = pcnt;
    wdog_n  = wdog;
    grant_n = grant;
    done_n  = '0;
    err_n   = 1'b0;
    send_n  = send_q;
    data_n  = data_q;
    unique case (state)
      IDLE: begin
        if (any) begin
          state_n = ISSUE;
          grant_n = N_REQ'(1) << sel;
          send_n  = 1'b1;
          data_n  = rd[sel];
          ptr_n   = sel_nxt;
          pcnt_n  = '0;
          wdog_n  = '0;
        end
      end
      ISSUE: begin
        wdog_n = wdog + WDW'(1);
        if (tout) begin
          state_n = DONE;
          send_n  = 1'b0;
          done_n  = grant;
          err_n   = 1'b1;
        end else if (pcnt == PC_LAST) begin
          state_n = WAIT_LOW;
          send_n  = 1'b0;
        end else begin
          pcnt_n = pcnt + PCW'(1);
        end
      end
      WAIT_LOW: begin
        wdog_n = wdog + WDW'(1);
        if (tout) begin
          state_n = DONE;
          done_n  = grant;
          err_n   = 1'b1;
        end else if (!uart.uart_sent) begin
          state_n = WAIT_SENT;
        end
      end
      WAIT_SENT: begin
        wdog_n = wdog + WDW'(1);
        if (uart.uart_sent) begin
          state_n = DONE;
          done_n  = grant;
        end else if (tout) begin
          state_n = DONE;
          done_n  = grant;
          err_n   = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        grant_n = '0;
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        send_n  = 1'b0;
      end
    endcase
  end

  // State and all outputs registered; reset aborts silently.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state  <= IDLE;
      ptr    <= '0;
      pcnt   <= '0;
      wdog   <= '0;
      grant  <= '0;
      done   <= '0;
      err    <= 1'b0;
      busy   <= 1'b0;
      send_q <= 1'b0;
      data_q <= '0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      pcnt   <= pcnt_n;
      wdog   <= wdog_n;
      grant  <= grant_n;
      done   <= done_n;
      err    <= err_n;
      busy   <= (state_n != IDLE);
      send_q <= send_n;
      data_q <= data_n;
    end
  end

endmodule
